// File: rtl/instr_decode.sv
// Decode stage: MIPS word -> ALU op ID plus operands from an owned 32x32 register file,
// presented as a registered bundle behind a valid/ready handshake.
module instr_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr_ID,
    output logic [31:0] rs,
    output logic [31:0] rt,
    output logic [4:0]  dest,
    output logic [31:0] initial_pc,
    output logic        illegal
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 32;

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic            w_capture;

    logic [XLEN-1:0] r_regs [NREG];

    logic [5:0]      w_opcode;
    logic [5:0]      w_funct;
    logic [AW-1:0]   w_rs_addr;
    logic [AW-1:0]   w_rt_addr;
    logic [AW-1:0]   w_rd_addr;
    logic [4:0]      w_shamt;
    logic [15:0]     w_imm;
    logic [XLEN-1:0] w_rs_val;
    logic [XLEN-1:0] w_rt_val;

    logic [XLEN-1:0] w_id;
    logic [XLEN-1:0] w_opa;
    logic [XLEN-1:0] w_opb;
    logic [AW-1:0]   w_dest;
    logic            w_illegal;

    logic [XLEN-1:0] r_instr_id;
    logic [XLEN-1:0] r_rs;
    logic [XLEN-1:0] r_rt;
    logic [AW-1:0]   r_dest;
    logic [XLEN-1:0] r_pc;
    logic            r_illegal;

    assign out_valid  = (r_state == S_FULL);
    assign in_ready   = !rst && (!out_valid || out_ready);
    assign w_capture  = in_valid && in_ready;

    assign instr_ID   = r_instr_id;
    assign rs         = r_rs;
    assign rt         = r_rt;
    assign dest       = r_dest;
    assign initial_pc = r_pc;
    assign illegal    = r_illegal;

    // Output bundle occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_capture) w_state_nxt = S_FULL;
            S_FULL:  if (out_ready && !w_capture) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // Register file; entry 0 is cleared by reset and never written, so it reads 0
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    assign w_opcode  = in_instr[31:26];
    assign w_funct   = in_instr[5:0];
    assign w_rs_addr = in_instr[25:21];
    assign w_rt_addr = in_instr[20:16];
    assign w_rd_addr = in_instr[15:11];
    assign w_shamt   = in_instr[10:6];
    assign w_imm     = in_instr[15:0];

    // Read ports with writeback bypass so a same-cycle write is visible at capture
    always_comb begin
        w_rs_val = r_regs[w_rs_addr];
        w_rt_val = r_regs[w_rt_addr];
        if (wb_en && (wb_addr != '0) && (wb_addr == w_rs_addr)) w_rs_val = wb_data;
        if (wb_en && (wb_addr != '0) && (wb_addr == w_rt_addr)) w_rt_val = wb_data;
    end

    always_comb begin
        w_id      = '0;
        w_opa     = '0;
        w_opb     = '0;
        w_dest    = '0;
        w_illegal = 1'b1;
        case (w_opcode)
            6'h00: begin
                w_opa     = w_rs_val;
                w_opb     = w_rt_val;
                w_dest    = w_rd_addr;
                w_illegal = 1'b0;
                case (w_funct)
                    6'h20: w_id = XLEN'(1);
                    6'h22: w_id = XLEN'(2);
                    6'h21: w_id = XLEN'(3);
                    6'h23: w_id = XLEN'(4);
                    6'h24: w_id = XLEN'(7);
                    6'h25: w_id = XLEN'(8);
                    6'h00: begin
                        w_id  = XLEN'(11);
                        w_opa = w_rt_val;
                        w_opb = XLEN'(w_shamt);
                    end
                    6'h02: begin
                        w_id  = XLEN'(12);
                        w_opa = w_rt_val;
                        w_opb = XLEN'(w_shamt);
                    end
                    default: begin
                        w_opa     = '0;
                        w_opb     = '0;
                        w_dest    = '0;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            6'h08, 6'h09: begin
                w_id      = (w_opcode == 6'h08) ? XLEN'(5) : XLEN'(6);
                w_opa     = w_rs_val;
                w_opb     = {{16{w_imm[15]}}, w_imm};
                w_dest    = w_rt_addr;
                w_illegal = 1'b0;
            end
            6'h0C, 6'h0D: begin
                w_id      = (w_opcode == 6'h0C) ? XLEN'(9) : XLEN'(10);
                w_opa     = w_rs_val;
                w_opb     = {16'h0000, w_imm};
                w_dest    = w_rt_addr;
                w_illegal = 1'b0;
            end
            default: ;
        endcase
    end

    // Bundle register loads only at capture, so later writebacks cannot disturb it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_id <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_dest     <= '0;
            r_pc       <= '0;
            r_illegal  <= 1'b0;
        end else if (w_capture) begin
            r_instr_id <= w_id;
            r_rs       <= w_opa;
            r_rt       <= w_opb;
            r_dest     <= w_dest;
            r_pc       <= in_pc;
            r_illegal  <= w_illegal;
        end
    end

endmodule

// File: tb/tb_instr_decode.sv
// Scoreboard bench for instr_decode: directed test-plan items, then random traffic
// checked against a table-driven decode and register-file model.
module tb_instr_decode;

    typedef struct packed {
        logic [31:0] id;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic        ill;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] instr_ID;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  dest;
    logic [31:0] initial_pc;
    logic        illegal;

    int          n_checks = 0;
    int          n_errors = 0;

    bundle_t     sb[$];
    logic [31:0] mregs[32];
    logic        m_full = 1'b0;
    int          rmap[int];
    int          imap[int];
    logic [5:0]  fn_list[8] = '{6'h20, 6'h22, 6'h21, 6'h23, 6'h24, 6'h25, 6'h00, 6'h02};
    logic [5:0]  op_list[4] = '{6'h08, 6'h09, 6'h0C, 6'h0D};

    bundle_t     snap;
    logic        held_pending = 1'b0;

    instr_decode dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr_ID(instr_ID), .rs(rs), .rt(rt), .dest(dest),
        .initial_pc(initial_pc), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd(input logic [4:0] a, input logic wbe,
                                       input logic [4:0] wba, input logic [31:0] wbd);
        if (a == 5'd0) return 32'd0;
        if (wbe && wba == a) return wbd;
        return mregs[a];
    endfunction

    // Reference decode from the opcode/funct tables
    function automatic bundle_t model(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic wbe, input logic [4:0] wba, input logic [31:0] wbd);
        bundle_t     r;
        int          op;
        int          fn;
        logic [15:0] imm;
        op  = int'(ins[31:26]);
        fn  = int'(ins[5:0]);
        imm = ins[15:0];
        r   = '0;
        r.pc = pc;
        if (op == 0 && rmap.exists(fn)) begin
            r.id   = 32'(rmap[fn]);
            r.dest = ins[15:11];
            if (rmap[fn] >= 11) begin
                r.a = rd(ins[20:16], wbe, wba, wbd);
                r.b = 32'(ins[10:6]);
            end else begin
                r.a = rd(ins[25:21], wbe, wba, wbd);
                r.b = rd(ins[20:16], wbe, wba, wbd);
            end
        end else if (op != 0 && imap.exists(op)) begin
            r.id   = 32'(imap[op]);
            r.a    = rd(ins[25:21], wbe, wba, wbd);
            r.b    = (op == 8 || op == 9) ? 32'(signed'(imm)) : 32'(imm);
            r.dest = ins[20:16];
        end else begin
            r.ill = 1'b1;
        end
        return r;
    endfunction

    // One clock of stimulus; model state advances with the decision for this edge
    task automatic cycle(input logic r, input logic vld, input logic [31:0] ins,
                         input logic [31:0] pc, input logic wbe, input logic [4:0] wba,
                         input logic [31:0] wbd, input logic ordy);
        logic exp_ready;
        @(posedge clk);
        #1;
        rst = r; in_valid = vld; in_instr = ins; in_pc = pc;
        wb_en = wbe; wb_addr = wba; wb_data = wbd; out_ready = ordy;
        #1;
        exp_ready = !r && (!m_full || ordy);
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        if (r) begin
            sb.delete();
            m_full = 1'b0;
            for (int i = 0; i < 32; i++) mregs[i] = '0;
        end else begin
            if (vld && exp_ready) sb.push_back(model(ins, pc, wbe, wba, wbd));
            if (wbe && wba != 5'd0) mregs[wba] = wbd;
            m_full = (vld && exp_ready) ? 1'b1 : (ordy ? 1'b0 : m_full);
        end
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, ordy);
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic ordy);
        cycle(1'b0, 1'b1, ins, pc, 1'b0, 5'd0, 32'd0, ordy);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, a, d, 1'b1);
    endtask

    function automatic logic [31:0] rand_instr();
        int          k;
        logic [4:0]  s;
        logic [4:0]  t;
        logic [4:0]  d;
        logic [5:0]  f;
        logic [5:0]  o;
        k = int'($urandom_range(0, 9));
        s = 5'($urandom_range(0, 7));
        t = 5'($urandom_range(0, 7));
        d = 5'($urandom_range(0, 31));
        f = fn_list[$urandom_range(0, 7)];
        o = op_list[$urandom_range(0, 3)];
        if (k < 4) return {6'h00, s, t, d, 5'($urandom), f};
        if (k < 7) return {o, s, t, 16'($urandom)};
        return $urandom();
    endfunction

    // Monitor: pop on each transfer, and confirm a stalled bundle stays frozen
    always @(negedge clk) begin
        bundle_t e;
        if (held_pending) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_id", instr_ID, snap.id);
            chk("hold_rs", rs, snap.a);
            chk("hold_rt", rt, snap.b);
            chk("hold_dest", 32'(dest), 32'(snap.dest));
            chk("hold_pc", initial_pc, snap.pc);
        end
        held_pending = !rst && out_valid && !out_ready;
        snap = '{id: instr_ID, a: rs, b: rt, dest: dest, pc: initial_pc, ill: illegal};
        if (!rst && out_valid && out_ready) begin
            chk("sb_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("instr_ID", instr_ID, e.id);
                chk("rs", rs, e.a);
                chk("rt", rt, e.b);
                chk("dest", 32'(dest), 32'(e.dest));
                chk("initial_pc", initial_pc, e.pc);
                chk("illegal", 32'(illegal), 32'(e.ill));
            end
        end
    end

    initial begin
        rmap[32'h20] = 1;  rmap[32'h22] = 2;  rmap[32'h21] = 3;  rmap[32'h23] = 4;
        rmap[32'h24] = 7;  rmap[32'h25] = 8;  rmap[32'h00] = 11; rmap[32'h02] = 12;
        imap[32'h08] = 5;  imap[32'h09] = 6;  imap[32'h0C] = 9;  imap[32'h0D] = 10;
        for (int i = 0; i < 32; i++) mregs[i] = '0;

        // Reset with a writeback that must be ignored
        cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 5'd5, 32'h0000FFFF, 1'b1);
        cycle(1'b1, 1'b1, 32'h00432020, 32'd0, 1'b1, 5'd5, 32'h0000FFFF, 1'b1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_instr_ID", instr_ID, 32'd0);
        chk("rst_rs", rs, 32'd0);
        chk("rst_rt", rt, 32'd0);
        chk("rst_dest", 32'(dest), 32'd0);
        chk("rst_initial_pc", initial_pc, 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        idle(1'b1);
        issue(32'h00A00820, 32'h0000_0040, 1'b1);
        idle(1'b1);
        chk("post_rst_reg5", rs, 32'd0);

        // R-type with explicit expected values
        wr(5'd2, 32'd7);
        wr(5'd3, 32'd5);
        issue(32'h00432020, 32'h0000_0100, 1'b1);
        idle(1'b1);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_id", instr_ID, 32'd1);
        chk("add_rs", rs, 32'd7);
        chk("add_rt", rt, 32'd5);
        chk("add_dest", 32'(dest), 32'd4);
        chk("add_pc", initial_pc, 32'h100);

        // Immediates and shift, back to back
        issue(32'h2046FFFF, 32'h104, 1'b1);
        issue(32'h3447FFFF, 32'h108, 1'b1);
        issue(32'h000208C0, 32'h10C, 1'b1);
        idle(1'b1);
        chk("sll_id", instr_ID, 32'd11);
        chk("sll_rs", rs, 32'd7);
        chk("sll_rt", rt, 32'd3);

        // Bypass on same-cycle write, and $0 stays zero
        cycle(1'b0, 1'b1, 32'h00432020, 32'h110, 1'b1, 5'd2, 32'd9, 1'b1);
        idle(1'b1);
        chk("bypass_rs", rs, 32'd9);
        wr(5'd0, 32'h55);
        issue(32'h00002020, 32'h114, 1'b1);
        idle(1'b1);
        chk("r0_rs", rs, 32'd0);

        // Backpressure: first accepted, two stalled cycles, then drain in order
        issue(32'h00432022, 32'h200, 1'b1);
        issue(32'h00432024, 32'h204, 1'b0);
        issue(32'h00432024, 32'h204, 1'b0);
        issue(32'h00432024, 32'h204, 1'b1);
        issue(32'h00432025, 32'h208, 1'b1);
        idle(1'b1);

        // Illegal opcode
        issue(32'hFC000000, 32'h300, 1'b1);
        idle(1'b1);
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_id", instr_ID, 32'd0);
        idle(1'b1);

        // Random traffic with occasional mid-stream reset
        for (int n = 0; n < 800; n++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), rand_instr(),
                  $urandom(), $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                  $urandom(), ($urandom_range(0, 3) != 0));
        end

        for (int n = 0; n < 4; n++) idle(1'b1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
